// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
// Build option: SERIAL_SUB_FLAGS_EN (see serial_sub_ctrl) does not affect this package.
package serial_sub_pkg;

  localparam int unsigned W_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_t;

endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor cell: s = a - b - ci, with borrow out co.
// Ports:
//   a  - minuend bit
//   b  - subtrahend bit
//   ci - borrow in
//   co - borrow out
//   s  - difference bit
module full_sub (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  assign s  = a ^ b ^ ci;
  assign co = (~a & b) | (~a & ci) | (b & ci);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: computes diff = a - b - bin (mod 2**W), LSB first, one
// bit per clock through a single shared full_sub cell.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - request, sampled only while ready=1
//   a, b, bin     - operands, captured on an accepted start
//   ready         - high in IDLE and DONE
//   busy          - high while bits are being processed
//   done          - one-cycle pulse, result valid
//   diff, bout    - result and final borrow, held until the next result is ready
//   zero, ovf     - result flags, present only when SERIAL_SUB_FLAGS_EN is defined
// Build option: define SERIAL_SUB_FLAGS_EN to add the zero/ovf outputs.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);

  if ((2 ** CNT_W) <= W) begin : g_bad_cnt_w
    $error("CNT_W too small for W");
  end

  state_t         state_q;
  logic [W-1:0]   a_sh_q;
  logic [W-1:0]   b_sh_q;
  logic [W-1:0]   res_sh_q;
  logic           brw_q;
  logic [CNT_W-1:0] cnt_q;

  logic           fs_s;
  logic           fs_co;
  logic [W-1:0]   res_next;
  logic           last_bit;

`ifdef SERIAL_SUB_FLAGS_EN
  // Operand sign bits are shifted out of a_sh/b_sh, so keep them for the overflow flag.
  logic           a_msb_q;
  logic           b_msb_q;
`else
  // Flags disabled: no sign-bit capture and no zero/ovf state.
`endif

  full_sub u_full_sub (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (brw_q),
    .co (fs_co),
    .s  (fs_s)
  );

  always_comb begin
    res_next = {fs_s, res_sh_q[W-1:1]};
    last_bit = (cnt_q == CNT_W'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero     <= 1'b0;
      ovf      <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            state_q <= StRun;
            ready   <= 1'b0;
            busy    <= 1'b1;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_q <= a[W-1];
            b_msb_q <= b[W-1];
`endif
          end else begin
            state_q <= StIdle;
            ready   <= 1'b1;
          end
        end
        StRun: begin
          res_sh_q <= res_next;
          a_sh_q   <= {1'b0, a_sh_q[W-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[W-1:1]};
          brw_q    <= fs_co;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit) begin
            // Only the completed result ever reaches diff.
            state_q <= StDone;
            diff    <= res_next;
            bout    <= fs_co;
            done    <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero    <= (res_next == '0);
            ovf     <= (a_msb_q != b_msb_q) && (res_next[W-1] != a_msb_q);
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          ready   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
